// File: rtl/net_resolver_pkg.sv
// Shared types and constants for the multi-driver net resolution engine.
package net_resolver_pkg;

  localparam int          MODE_W  = 3;
  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [MODE_W-1:0] {
    MODE_WIRE   = 3'd0,
    MODE_WAND   = 3'd1,
    MODE_WOR    = 3'd2,
    MODE_TRI0   = 3'd3,
    MODE_TRI1   = 3'd4,
    MODE_TRIREG = 3'd5
  } net_mode_e;

  // Unassigned encodings fall back to plain wire resolution.
  function automatic net_mode_e decode_mode(input logic [MODE_W-1:0] raw);
    case (raw)
      3'd1:    return MODE_WAND;
      3'd2:    return MODE_WOR;
      3'd3:    return MODE_TRI0;
      3'd4:    return MODE_TRI1;
      3'd5:    return MODE_TRIREG;
      default: return MODE_WIRE;
    endcase
  endfunction

endpackage

// File: rtl/net_charge_cell.sv
// One bit of trireg charge: retention counter plus the last driven value.
module net_charge_cell #(
  parameter int unsigned CHARGE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  input  logic val_i,
  output logic charged_o,
  output logic held_o
);

  localparam logic [7:0] CHARGE_INIT = 8'(CHARGE_CYCLES);

  logic [7:0] cnt_q, cnt_d, cnt_eff;
  logic       held_q, held_d;

  // Clear acts before evaluation, so a load on the same sample still wins.
  assign cnt_eff   = clr_i ? 8'd0 : cnt_q;
  assign charged_o = (cnt_eff != 8'd0);
  assign held_o    = held_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    cnt_d  = cnt_eff;
    held_d = held_q;
    if (load_i) begin
      cnt_d  = CHARGE_INIT;
      held_d = val_i;
    end else if (dec_i && charged_o) begin
      cnt_d = cnt_eff - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      cnt_q  <= '0;
      held_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      held_q <= held_d;
    end
  end

endmodule

// File: rtl/net_resolver.sv
// Resolves N_DRV tristate drivers onto a WIDTH-bit net under a run-time
// selectable net type, with float flags and contention diagnostics.
module net_resolver
  import net_resolver_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int N_DRV         = 4,
  parameter int CHARGE_CYCLES = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MODE_W-1:0]                 mode,
  input  logic [N_DRV-1:0]                  drv_en,
  input  logic [N_DRV-1:0][WIDTH-1:0]       drv_data,
  output logic [WIDTH-1:0]                  net_out,
  output logic [WIDTH-1:0]                  net_z,
  output logic [WIDTH-1:0]                  contention,
  output logic [15:0]                       contention_count
);

  net_mode_e         mode_e;
  logic [MODE_W-1:0] mode_q;
  logic              mode_change;
  logic [WIDTH-1:0]  d1, d0;
  logic [WIDTH-1:0]  chg_clr, chg_load, chg_dec, charged, held;
  logic [WIDTH-1:0]  net_out_q, net_out_d, net_z_q, net_z_d, cont_q, cont_d;
  logic [15:0]       cnt_q, cnt_d;

  assign mode_e      = decode_mode(mode);
  assign mode_change = (mode != mode_q);

  always_comb begin
    d1 = '0;
    d0 = '0;
    for (int i = 0; i < N_DRV; i++) begin
      if (drv_en[i]) begin
        d1 = d1 | drv_data[i];
        d0 = d0 | ~drv_data[i];
      end
    end
  end

  // Charge only lives in trireg mode; any mode change drops it.
  always_comb begin
    chg_clr  = {WIDTH{mode_change || (mode_e != MODE_TRIREG)}};
    chg_load = '0;
    chg_dec  = '0;
    if (mode_e == MODE_TRIREG) begin
      chg_load = d1 ^ d0;
      chg_dec  = ~(d1 | d0);
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_charge
    net_charge_cell #(.CHARGE_CYCLES(CHARGE_CYCLES)) u_cell (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (chg_clr[b]),
      .load_i    (chg_load[b]),
      .dec_i     (chg_dec[b]),
      .val_i     (d1[b]),
      .charged_o (charged[b]),
      .held_o    (held[b])
    );
  end

  always_comb begin
    net_out_d = net_out_q;
    net_z_d   = net_z_q;
    cont_d    = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (d1[b] && d0[b]) begin
        if (mode_e == MODE_WAND) begin
          net_out_d[b] = 1'b0;
          net_z_d[b]   = 1'b0;
        end else if (mode_e == MODE_WOR) begin
          net_out_d[b] = 1'b1;
          net_z_d[b]   = 1'b0;
        end else begin
          cont_d[b] = 1'b1;   // value and float flag both hold
        end
      end else if (d1[b] || d0[b]) begin
        net_out_d[b] = d1[b];
        net_z_d[b]   = 1'b0;
      end else begin
        case (mode_e)
          MODE_TRI0: begin net_out_d[b] = 1'b0;     net_z_d[b] = 1'b0; end
          MODE_TRI1: begin net_out_d[b] = 1'b1;     net_z_d[b] = 1'b0; end
          MODE_TRIREG: begin
            net_out_d[b] = charged[b] & held[b];
            net_z_d[b]   = ~charged[b];
          end
          default:   begin net_out_d[b] = 1'b0;     net_z_d[b] = 1'b1; end
        endcase
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((|cont_q) && (cnt_q != CNT_SAT)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_WIRE;
      net_out_q <= '0;
      net_z_q   <= '1;
      cont_q    <= '0;
      cnt_q     <= '0;
    end else begin
      mode_q    <= mode;
      net_out_q <= net_out_d;
      net_z_q   <= net_z_d;
      cont_q    <= cont_d;
      cnt_q     <= cnt_d;
    end
  end

  assign net_out          = net_out_q;
  assign net_z            = net_z_q;
  assign contention       = cont_q;
  assign contention_count = cnt_q;

endmodule

// File: doc/net_resolver.md
# net_resolver

Parametrised multi-driver net resolution engine. It models, in synthesizable two-state logic, the resolution rules of wire, tri, wand, wor, tri0, tri1 and trireg nets for a WIDTH-bit bus with N_DRV tristate drivers. Mode is selectable at run time, and trireg charge retention has programmable decay. It sits between on-chip shared-bus driver models and consumers that need a resolved value, a per-bit float indication and contention diagnostics.

## Interface
- WIDTH, 8: bus width in bits (≥1)
- N_DRV, 4: number of drivers (≥1)
- CHARGE_CYCLES, 3: undriven samples a trireg bit keeps its charge (0..255; 0 = no retention)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- mode  in  3  0 WIRE/TRI, 1 WAND/TRIAND, 2 WOR/TRIOR, 3 TRI0, 4 TRI1, 5 TRIREG; 6–7 behave as WIRE
- drv_en  in  N_DRV  per-driver enable (0 = high-Z)
- drv_data  in  N_DRV×WIDTH  driver values, packed [N_DRV-1:0][WIDTH-1:0]
- net_out  out  WIDTH  resolved value (0 where floating)
- net_z  out  WIDTH  1 = bit floating (undriven, no pull, no charge)
- contention  out  WIDTH  1 = bit saw opposing drivers in a non-wired mode
- contention_count  out  16  saturating count of cycles with any contention bit set

## Operation
- Per bit, each cycle: d1 = any enabled driver drives 1; d0 = any enabled driver drives 0.
- WIRE: d1&!d0 → 1; d0&!d1 → 0; d1&d0 → contention, net_out keeps its previous value; neither → float.
- WAND: d0 → 0; else d1 → 1; neither → float. Never flags contention.
- WOR: d1 → 1; else d0 → 0; neither → float. Never flags contention.
- TRI0 / TRI1: as WIRE, but neither → 0 / 1 with net_z=0.
- TRIREG: as WIRE while driven. A per-bit charge counter loads CHARGE_CYCLES on every sample where exactly one polarity is driven.
  - Undriven sample, counter>0: hold the last driven value, net_z=0, decrement the counter.
  - Undriven sample, counter==0: float.
  - Contention: hold the value, do not reload the counter.
- Floating bit: net_out=0, net_z=1. Floating, contention and driven are mutually exclusive per bit, except that contention bits keep net_z at its previous value.
- contention_count increments by 1 on each cycle where the registered contention vector is nonzero, and saturates at 16'hFFFF.
- Mode change: mode is registered internally. On any cycle where the sampled mode differs from the previous registered mode, all charge counters clear to 0 before evaluation, so no charge survives a mode change. contention_count is not cleared.

## Timing
- All outputs are registered; latency is 1 cycle from the drv_en/drv_data/mode sample to the outputs.
- Reset (synchronous, dominates all inputs):
  - net_out=0, net_z all ones, contention=0, contention_count=0
  - charge counters=0, registered mode=WIRE
- First evaluated sample is the cycle after reset deasserts.
- Trireg decay with CHARGE_CYCLES=C: last driven sample at edge T; undriven samples at T+1..T+C hold; the sample at T+C+1 floats.
- Reset asserted mid-decay drops charge immediately; output floats at the next edge.

## Structure
- Package net_resolver_pkg: net_mode_e enum (the six modes), MODE_W=3, CNT_SAT=16'hFFFF.
- Sub-module net_charge_cell: one bit of charge state (counter, held value, load/decrement/clear), instantiated WIDTH times.
- Top level: per-bit d0/d1 OR-reduction across drivers, mode multiplexer, output registers and the saturating counter.

## Test plan
- Reset, then WIRE with drv_en=0 → after 1 cycle net_out=8'h00, net_z=8'hFF, contention=0.
- WIRE, driver0 drives 8'hA5 and driver1 drives 8'h5A, both enabled, on the cycle after net_out=8'hA5 → contention=8'hFF, net_out stays 8'hA5; held for 3 cycles → contention_count=3.
- WAND/WOR, drivers 8'hF0 and 8'h3C both enabled → WAND net_out=8'h30, WOR net_out=8'hFC, contention=0, net_z=0.
- TRI0 then TRI1, all drivers disabled → net_out=8'h00 then 8'hFF, net_z=0 in both.
- TRIREG, C=3, drive 8'h81 for one cycle then release → net_out=8'h81 for 3 further output cycles, then 8'h00 with net_z=8'hFF. Repeat with mode switched to WIRE and back mid-hold → floats on the next sample. Repeat with reset mid-hold → floats immediately.
- Contention held 70000 cycles → contention_count saturates at 16'hFFFF and stays; reset → 0.
